// File: rtl/geom_mem_arbiter.sv
// rtl/geom_mem_arbiter.sv - shares one geometry RAM port between SPI writes and frame-driver reads
// Fixed-latency read tagging plus forced write slots so uploads are not starved during long draws.
module geom_mem_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 108,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_active,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_pending
);

  localparam logic [1:0] ST_UPLOAD = 2'd0;
  localparam logic [1:0] ST_DRAW   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
  logic              wait_full;

  assign wait_full = (wait_q >= 4'(MAX_WAIT));

  // Grants are masked while reset is asserted so nothing reaches the RAM.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_UPLOAD: begin
          wr_gnt = wr_req;
          rd_gnt = rd_req & ~wr_req;
        end
        ST_DRAW: begin
          wr_gnt = wr_req & (wait_full | ~rd_req);
          rd_gnt = rd_req & ~(wr_req & wait_full);
        end
        ST_DRAIN: begin
          rd_gnt = rd_req;
        end
        default: begin
          wr_gnt = 1'b0;
          rd_gnt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_en    = wr_gnt | rd_gnt;
    mem_we    = wr_gnt;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wr_gnt) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (rd_gnt) begin
      mem_addr  = rd_addr;
    end
  end

  always_comb begin
    wait_d = 4'd0;
    if (wr_req && !wr_gnt) begin
      wait_d = wait_full ? wait_q : wait_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UPLOAD: if (frame_active) state_d = ST_DRAW;
      ST_DRAW:   if (!frame_active) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (frame_active)     state_d = ST_DRAW;
        else if (!rd_pending) state_d = ST_UPLOAD;
      end
      default:                state_d = ST_UPLOAD;
    endcase
  end

  // One bit per cycle of RAM latency; the last stage marks mem_rdata as valid.
  always_comb begin
    vld_sr_d    = '0;
    vld_sr_d[0] = rd_gnt;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_UPLOAD;
      wait_q   <= 4'd0;
      vld_sr_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      vld_sr_q <= vld_sr_d;
    end
  end

  assign rd_valid   = vld_sr_q[RD_LAT-1];
  assign rd_pending = |vld_sr_q;
  assign rd_data    = mem_rdata;

endmodule

// File: tb/tb_geom_mem_arbiter.sv
// tb/tb_geom_mem_arbiter.sv - scoreboard bench for geom_mem_arbiter
// A read-first RAM model sits on the mem_* port; expected read data comes from a shadow copy.
module tb_geom_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 108;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_active;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_pending;

  geom_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .frame_active(frame_active),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_pending(rd_pending)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_p1, ram_p2;

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) ram_p1 <= ram[mem_addr];
    ram_p2 <= ram_p1;
  end
  assign mem_rdata = ram_p2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int               cyc;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] shadow [int];
  int                cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_data", rd_data, e.data);
        end
      end
      if (rd_gnt) begin
        e.cyc  = cyc + RD_LAT;
        e.data = shadow.exists(int'(rd_addr)) ? shadow[int'(rd_addr)] : '0;
        exp_q.push_back(e);
      end
      if (wr_gnt) shadow[int'(wr_addr)] = wr_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic got = 1'b0;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = wr_gnt;
      step();
    end
    wr_req = 1'b0;
    check("wr_done", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; frame_active = 1'b0;
    wr_req = 1'b1; wr_addr = 13'h010; wr_data = '0;
    rd_req = 1'b1; rd_addr = 13'h020;
    repeat (2) step();
    @(negedge clk);
    check("rst_wr_gnt", wr_gnt, 0);
    check("rst_rd_gnt", rd_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_pending", rd_pending, 0);
    step();
    rst_n = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    step();

    do_write(13'h020, 108'h2020);
    do_write(13'h030, 108'h3030);

    // Upload: write beats simultaneous read
    wr_req = 1'b1; wr_addr = 13'h010; wr_data = 108'h1010;
    rd_req = 1'b1; rd_addr = 13'h020;
    @(negedge clk);
    check("t1_wr_gnt", wr_gnt, 1);
    check("t1_rd_gnt", rd_gnt, 0);
    check("t1_mem_we", mem_we, 1);
    check("t1_mem_addr", mem_addr, 13'h010);
    check("t1_mem_wdata", mem_wdata, 108'h1010);
    step();
    wr_req = 1'b0;
    @(negedge clk);
    check("t1_rd_gnt2", rd_gnt, 1);
    check("t1_mem_addr2", mem_addr, 13'h020);
    step();
    rd_req = 1'b0;

    // Read latency and rd_pending
    do_write(13'h005, 108'h0ABC);
    frame_active = 1'b1; rd_req = 1'b1; rd_addr = 13'h005;
    @(negedge clk);
    check("t2_rd_gnt", rd_gnt, 1);
    step();
    rd_req = 1'b0;
    @(negedge clk);
    check("t2_pend1", rd_pending, 1);
    check("t2_valid1", rd_valid, 0);
    step();
    @(negedge clk);
    check("t2_valid2", rd_valid, 1);
    check("t2_data", rd_data, 108'h0ABC);
    check("t2_pend2", rd_pending, 1);
    step();
    @(negedge clk);
    check("t2_pend3", rd_pending, 0);
    step();

    // Draw: write forced after MAX_WAIT denials, twice
    rd_req = 1'b1; rd_addr = 13'h030;
    wr_req = 1'b1; wr_addr = 13'h040; wr_data = 108'h444;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t3_deny%0d", k), wr_gnt, 0);
      check($sformatf("t3_rd%0d", k), rd_gnt, 1);
      step();
    end
    @(negedge clk);
    check("t3_force_wr", wr_gnt, 1);
    check("t3_force_rd", rd_gnt, 0);
    check("t3_force_addr", mem_addr, 13'h040);
    step();
    wr_addr = 13'h041; wr_data = 108'h555;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t3_deny_b%0d", k), wr_gnt, 0);
      step();
    end
    @(negedge clk);
    check("t3_force_wr2", wr_gnt, 1);
    step();
    wr_req = 1'b0;
    @(negedge clk);
    check("t3_rd_after", rd_gnt, 1);
    step();
    rd_req = 1'b0;
    repeat (3) step();

    // Drain: back-to-back reads, write held off until reads return
    rd_req = 1'b1; rd_addr = 13'h005;
    @(negedge clk);
    check("t4_g1", rd_gnt, 1);
    step();
    rd_addr = 13'h040;
    @(negedge clk);
    check("t4_g2", rd_gnt, 1);
    step();
    rd_addr = 13'h041; frame_active = 1'b0;
    @(negedge clk);
    check("t4_g3", rd_gnt, 1);
    step();
    rd_req = 1'b0;
    wr_req = 1'b1; wr_addr = 13'h050; wr_data = 108'h666;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t4_hold%0d", k), wr_gnt, 0);
      check($sformatf("t4_pend%0d", k), rd_pending, (k == 2) ? 1'b0 : 1'b1);
      step();
    end
    @(negedge clk);
    check("t4_wr_gnt", wr_gnt, 1);
    check("t4_wr_addr", mem_addr, 13'h050);
    check("t4_q_empty", exp_q.size(), 0);
    step();
    wr_req = 1'b0;

    // Reset while a read is in flight
    frame_active = 1'b1;
    repeat (2) step();
    rd_req = 1'b1; rd_addr = 13'h005;
    @(negedge clk);
    check("t5_rd_gnt", rd_gnt, 1);
    step();
    rst_n = 1'b0;
    wr_req = 1'b1; wr_addr = 13'h060; wr_data = 108'h777;
    rd_req = 1'b1; rd_addr = 13'h061;
    @(negedge clk);
    check("t5_rst_wr", wr_gnt, 0);
    check("t5_rst_rd", rd_gnt, 0);
    check("t5_rst_en", mem_en, 0);
    check("t5_rst_pend", rd_pending, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_upload_wr", wr_gnt, 1);
    check("t5_upload_rd", rd_gnt, 0);
    check("t5_no_valid0", rd_valid, 0);
    step();
    wr_req = 1'b0; rd_req = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t5_no_valid%0d", k), rd_valid, 0);
      step();
    end

    // Read-first: forced write right after a read of the same address
    frame_active = 1'b0;
    repeat (4) step();
    do_write(13'h007, 108'h123);
    frame_active = 1'b1;
    repeat (2) step();
    rd_req = 1'b1; rd_addr = 13'h030;
    wr_req = 1'b1; wr_addr = 13'h007; wr_data = 108'h999;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t6_deny%0d", k), wr_gnt, 0);
      step();
    end
    rd_addr = 13'h007;
    @(negedge clk);
    check("t6_rd7", rd_gnt, 1);
    check("t6_rd7_addr", mem_addr, 13'h007);
    step();
    rd_addr = 13'h030;
    @(negedge clk);
    check("t6_wr7", wr_gnt, 1);
    check("t6_wr7_addr", mem_addr, 13'h007);
    step();
    wr_req = 1'b0;
    @(negedge clk);
    check("t6_rd_next", rd_gnt, 1);
    step();
    rd_req = 1'b0;
    repeat (4) step();
    rd_req = 1'b1; rd_addr = 13'h007;
    @(negedge clk);
    check("t6_rd7_new", rd_gnt, 1);
    step();
    rd_req = 1'b0;
    repeat (4) step();
    frame_active = 1'b0;
    repeat (4) step();

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
